// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle controller: coin credit, phase timer, rinse
// passes, fill/heat timeouts and latched faults in one FSM.
// Ports: clock/reset (sync, active high); sig_* machine and operator
// inputs; state code, actuator enables, coin_Return pulse, done, fault,
// fault_Code and rinse_Count outputs.
// Optional build macro PREWASH_EN inserts a PREWASH phase after HEAT.
module wash_cycle_sequencer #(
  parameter int TIMER_WIDTH    = 16,
  parameter int COINS_REQUIRED = 2,
  parameter int NUM_RINSES     = 2,
  parameter int FILL_TIMEOUT   = 1000,
  parameter int HEAT_TIMEOUT   = 2000,
  parameter int WASH_TICKS     = 500,
  parameter int RINSE_TICKS    = 300,
  parameter int SPIN_TICKS     = 400,
  parameter int PREWASH_TICKS  = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sig_Lid_Closed,
  input  logic       sig_Coin,
  input  logic       sig_Cancel,
  input  logic       sig_Out_Of_Balance,
  input  logic       sig_Motor_Failure,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Fault_Clear,
  output logic [3:0] state,
  output logic       water_Intake,
  output logic       heater_On,
  output logic       motor_On,
  output logic       drain_On,
  output logic       coin_Return,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_Code,
  output logic [2:0] rinse_Count
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_READY   = 4'd1,
    S_FILL    = 4'd2,
    S_HEAT    = 4'd3,
    S_WASH    = 4'd4,
    S_RINSE   = 4'd5,
    S_SPIN    = 4'd6,
    S_DONE    = 4'd7,
    S_FAULT   = 4'd8,
    S_PREWASH = 4'd9
  } state_t;

`ifdef PREWASH_EN
  localparam state_t AFTER_HEAT = S_PREWASH;
`else
  localparam state_t AFTER_HEAT = S_WASH;
`endif

  localparam logic [TIMER_WIDTH-1:0] FILL_LAST =
    TIMER_WIDTH'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] HEAT_LAST =
    TIMER_WIDTH'(HEAT_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] WASH_LAST =
    TIMER_WIDTH'(WASH_TICKS - 1);
  localparam logic [TIMER_WIDTH-1:0] RINSE_LAST =
    TIMER_WIDTH'(RINSE_TICKS - 1);
  localparam logic [TIMER_WIDTH-1:0] SPIN_LAST =
    TIMER_WIDTH'(SPIN_TICKS - 1);
  localparam logic [TIMER_WIDTH-1:0] PRE_LAST =
    TIMER_WIDTH'(PREWASH_TICKS - 1);
  localparam logic [2:0] COIN_N  = 3'(COINS_REQUIRED);
  localparam logic [2:0] RINSE_N = 3'(NUM_RINSES);

  state_t                 st;
  logic [TIMER_WIDTH-1:0] timer;
  logic [2:0]             credit;
  logic                   washed;
  logic                   running;
  logic                   motor_st;

  assign running  = st inside {S_FILL, S_HEAT, S_PREWASH,
                               S_WASH, S_RINSE, S_SPIN};
  assign motor_st = st inside {S_PREWASH, S_WASH, S_RINSE, S_SPIN};

  assign state        = st;
  assign water_Intake = (st == S_FILL);
  assign heater_On    = (st == S_HEAT);
  assign motor_On     = motor_st;
  assign drain_On     = (st == S_SPIN) || (st == S_FAULT);
  assign done         = (st == S_DONE);
  assign fault        = (st == S_FAULT);

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= S_IDLE;
      timer       <= '0;
      credit      <= '0;
      washed      <= 1'b0;
      rinse_Count <= '0;
      fault_Code  <= '0;
      coin_Return <= 1'b0;
    end else begin
      coin_Return <= 1'b0;
      timer       <= timer + TIMER_WIDTH'(1);
      if (running && motor_st && sig_Motor_Failure) begin
        st         <= S_FAULT;
        timer      <= '0;
        fault_Code <= 2'd2;
      end else if (running && !sig_Lid_Closed) begin
        st         <= S_FAULT;
        timer      <= '0;
        fault_Code <= 2'd3;
      end else if (st == S_SPIN && sig_Out_Of_Balance) begin
        st         <= S_FAULT;
        timer      <= '0;
        fault_Code <= 2'd3;
      end else begin
        unique case (st)
          S_IDLE: begin
            // a coin arriving with cancel is handed straight back
            if (sig_Cancel) begin
              if (credit != 3'd0 || sig_Coin) coin_Return <= 1'b1;
              credit <= '0;
            end else if (sig_Coin) begin
              if (credit + 3'd1 == COIN_N) begin
                st     <= S_READY;
                timer  <= '0;
                credit <= '0;
              end else begin
                credit <= credit + 3'd1;
              end
            end
          end
          S_READY: begin
            if (sig_Cancel) begin
              st          <= S_IDLE;
              timer       <= '0;
              coin_Return <= 1'b1;
            end else if (sig_Lid_Closed) begin
              st    <= S_FILL;
              timer <= '0;
            end
          end
          S_FILL: begin
            if (sig_Full) begin
              st    <= (rinse_Count == 3'd0 && !washed)
                       ? S_HEAT : S_RINSE;
              timer <= '0;
            end else if (timer == FILL_LAST) begin
              st         <= S_FAULT;
              timer      <= '0;
              fault_Code <= 2'd1;
            end else if (sig_Cancel) begin
              st    <= S_SPIN;
              timer <= '0;
            end
          end
          S_HEAT: begin
            if (sig_Temperature) begin
              st    <= AFTER_HEAT;
              timer <= '0;
            end else if (timer == HEAT_LAST) begin
              st         <= S_FAULT;
              timer      <= '0;
              fault_Code <= 2'd1;
            end else if (sig_Cancel) begin
              st    <= S_SPIN;
              timer <= '0;
            end
          end
          S_PREWASH: begin
            if (timer == PRE_LAST) begin
              st    <= S_WASH;
              timer <= '0;
            end else if (sig_Cancel) begin
              st    <= S_SPIN;
              timer <= '0;
            end
          end
          S_WASH: begin
            if (timer == WASH_LAST) begin
              st     <= S_FILL;
              timer  <= '0;
              washed <= 1'b1;
            end else if (sig_Cancel) begin
              st    <= S_SPIN;
              timer <= '0;
            end
          end
          S_RINSE: begin
            if (timer == RINSE_LAST) begin
              rinse_Count <= rinse_Count + 3'd1;
              st    <= (rinse_Count + 3'd1 < RINSE_N)
                       ? S_FILL : S_SPIN;
              timer <= '0;
            end else if (sig_Cancel) begin
              st    <= S_SPIN;
              timer <= '0;
            end
          end
          S_SPIN: begin
            if (timer == SPIN_LAST) begin
              st    <= S_DONE;
              timer <= '0;
            end
          end
          S_DONE: begin
            if (!sig_Lid_Closed) begin
              st          <= S_IDLE;
              timer       <= '0;
              rinse_Count <= '0;
              washed      <= 1'b0;
            end
          end
          S_FAULT: begin
            if (sig_Fault_Clear) begin
              st          <= S_IDLE;
              timer       <= '0;
              fault_Code  <= '0;
              rinse_Count <= '0;
              credit      <= '0;
              washed      <= 1'b0;
            end
          end
          default: begin
            st    <= S_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Scoreboard bench for wash_cycle_sequencer: every state change or
// coin_Return pulse is popped against a queued expectation.
module tb_wash_cycle_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic lid = 1'b0, coin = 1'b0, cancel = 1'b0, oob = 1'b0;
  logic mf = 1'b0, full = 1'b0, temp = 1'b0, fclr = 1'b0;
  logic [3:0] state;
  logic water_Intake, heater_On, motor_On, drain_On;
  logic coin_Return, done, fault;
  logic [1:0] fault_Code;
  logic [2:0] rinse_Count;

  wash_cycle_sequencer #(
    .TIMER_WIDTH(16), .COINS_REQUIRED(2), .NUM_RINSES(2),
    .FILL_TIMEOUT(10), .HEAT_TIMEOUT(12), .WASH_TICKS(5),
    .RINSE_TICKS(3), .SPIN_TICKS(4), .PREWASH_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset),
    .sig_Lid_Closed(lid), .sig_Coin(coin), .sig_Cancel(cancel),
    .sig_Out_Of_Balance(oob), .sig_Motor_Failure(mf),
    .sig_Full(full), .sig_Temperature(temp),
    .sig_Fault_Clear(fclr),
    .state(state), .water_Intake(water_Intake),
    .heater_On(heater_On), .motor_On(motor_On),
    .drain_On(drain_On), .coin_Return(coin_Return),
    .done(done), .fault(fault), .fault_Code(fault_Code),
    .rinse_Count(rinse_Count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] st;
    logic [1:0] code;
    logic [2:0] rinse;
    logic       cr;
    int         dur;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [3:0] prev_st;
  int dur = 0;
  exp_t e;
  logic [15:0] act, want;
  logic chg;

  // water heater motor drain done fault, straight from the state table
  function automatic logic [5:0] outs(input logic [3:0] s);
    case (s)
      4'd2:       return 6'b100000;
      4'd3:       return 6'b010000;
      4'd4, 4'd5,
      4'd9:       return 6'b001000;
      4'd6:       return 6'b001100;
      4'd7:       return 6'b000010;
      4'd8:       return 6'b000101;
      default:    return 6'b000000;
    endcase
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      chg = (state != prev_st);
      if (chg || coin_Return) begin
        checks++;
        act = {state, fault_Code, rinse_Count, coin_Return,
               water_Intake, heater_On, motor_On, drain_On,
               done, fault};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h", act);
        end else begin
          e = q.pop_front();
          want = {e.st, e.code, e.rinse, e.cr, outs(e.st)};
          if (act != want || (chg && e.dur >= 0 && dur != e.dur)) begin
            errors++;
            $display("FAIL event got=%h dur=%0d want=%h dur=%0d",
                     act, dur, want, e.dur);
          end
        end
      end
      if (chg) dur = 1;
      else dur++;
      prev_st = state;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [1:0] c,
                      input logic [2:0] r, input logic cr,
                      input int d);
    exp_t x;
    x.st = s; x.code = c; x.rinse = r; x.cr = cr; x.dur = d;
    q.push_back(x);
  endtask

  task automatic p_coin();
    coin = 1'b1; tick(1); coin = 1'b0;
  endtask

  task automatic p_cancel();
    cancel = 1'b1; tick(1); cancel = 1'b0;
  endtask

  task automatic p_clear();
    fclr = 1'b1; tick(1); fclr = 1'b0;
  endtask

  task automatic wait_for(input logic [3:0] s, input int r);
    int n = 0;
    while (!(state == s && (r < 0 || rinse_Count == 3'(r)))
           && n < 300) begin
      tick(1);
      n++;
    end
    checks++;
    if (!(state == s && (r < 0 || rinse_Count == 3'(r)))) begin
      errors++;
      $display("FAIL wait_state got=%0d want=%0d", state, s);
    end
  endtask

  // READY .. WASH with full and temperature already high
  task automatic push_prefix();
    push(1, 0, 0, 0, -1);
    push(2, 0, 0, 0, 1);
    push(3, 0, 0, 0, 1);
`ifdef PREWASH_EN
    push(9, 0, 0, 0, 1);
    push(4, 0, 0, 0, 3);
`else
    push(4, 0, 0, 0, 1);
`endif
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    checks++;
    if ({state, fault_Code, rinse_Count, coin_Return, water_Intake,
         heater_On, motor_On, drain_On, done, fault} != 16'h0) begin
      errors++;
      $display("FAIL reset_state got=%0d code=%0d rinse=%0d",
               state, fault_Code, rinse_Count);
    end
    prev_st = state;
    dur = 0;
    mon_en = 1'b1;

    // full cycle
    lid = 1'b1; full = 1'b1; temp = 1'b1;
    push_prefix();
    push(2, 0, 0, 0, 5);
    push(5, 0, 0, 0, 1);
    push(2, 0, 1, 0, 3);
    push(5, 0, 1, 0, 1);
    push(6, 0, 2, 0, 3);
    push(7, 0, 2, 0, 4);
    push(0, 0, 0, 0, -1);
    p_coin(); p_coin();
    wait_for(7, -1);
    tick(2);
    lid = 1'b0;
    tick(3);

    // refunds
    push(0, 0, 0, 1, -1);
    p_coin(); p_cancel(); tick(2);
    push(0, 0, 0, 1, -1);
    coin = 1'b1; cancel = 1'b1; tick(1);
    coin = 1'b0; cancel = 1'b0; tick(2);
    push(0, 0, 0, 1, -1);
    p_coin(); tick(3); p_cancel(); tick(2);
    push(1, 0, 0, 0, -1);
    push(0, 0, 0, 1, 1);
    p_coin(); p_coin(); p_cancel(); tick(3);

    // fill timeout, fault ignores other inputs until cleared
    lid = 1'b1; full = 1'b0;
    push(1, 0, 0, 0, -1);
    push(2, 0, 0, 0, 1);
    push(8, 1, 0, 0, 10);
    p_coin(); p_coin();
    wait_for(8, -1);
    p_cancel(); p_coin(); tick(2);
    push(0, 0, 0, 0, -1);
    p_clear(); tick(2);

    // cancel in WASH, then motor failure beats imbalance in SPIN
    full = 1'b1;
    push_prefix();
    push(6, 0, 0, 0, -1);
    push(8, 2, 0, 0, 1);
    push(0, 0, 0, 0, -1);
    p_coin(); p_coin();
    wait_for(4, -1);
    p_cancel();
    mf = 1'b1; oob = 1'b1; tick(1);
    mf = 1'b0; oob = 1'b0;
    wait_for(8, -1);
    p_clear(); tick(2);

    // lid opened during WASH
    push_prefix();
    push(8, 3, 0, 0, -1);
    push(0, 0, 0, 0, -1);
    p_coin(); p_coin();
    wait_for(4, -1);
    lid = 1'b0; tick(1);
    wait_for(8, -1);
    p_clear(); tick(2);
    lid = 1'b1;

    // synchronous reset during the second rinse pass
    push_prefix();
    push(2, 0, 0, 0, 5);
    push(5, 0, 0, 0, 1);
    push(2, 0, 1, 0, 3);
    push(5, 0, 1, 0, 1);
    push(0, 0, 0, 0, -1);
    p_coin(); p_coin();
    wait_for(5, 1);
    tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
